// File: rtl/stack_exec_unit_if.sv
// Request/response bundle between the core controller and the operand-stack unit.
// The controller side issues opcodes and clears errors; the unit side reports stack state.
interface stack_exec_unit_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 5
);
   logic                  op_valid;
   logic                  op_ready;
   logic [3:0]            op_code;
   logic [DATA_WIDTH-1:0] din;
   logic                  err_clr;
   logic [DATA_WIDTH-1:0] tos;
   logic [DATA_WIDTH-1:0] nos;
   logic [CNT_WIDTH-1:0]  count;
   logic                  empty;
   logic                  full;
   logic                  carry;
   logic                  done;
   logic [1:0]            err_code;

   modport master (
      output op_valid, op_code, din, err_clr,
      input  op_ready, tos, nos, count, empty, full, carry, done, err_code
   );

   modport slave (
      input  op_valid, op_code, din, err_clr,
      output op_ready, tos, nos, count, empty, full, carry, done, err_code
   );
endinterface

// File: rtl/stack_exec_unit.sv
// Operand-stack execution unit: LIFO of DATA_WIDTH words executing one stack/ALU op per
// accepted request, halting in ERR on overflow, underflow or illegal opcode until cleared.
module stack_exec_unit #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   stack_exec_unit_if.slave  bus
);
   localparam int IDX_WIDTH = $clog2(DEPTH);
   localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_PUSH = 4'd1;
   localparam logic [3:0] OP_POP  = 4'd2;
   localparam logic [3:0] OP_DUP  = 4'd3;
   localparam logic [3:0] OP_SWAP = 4'd4;
   localparam logic [3:0] OP_OVER = 4'd5;
   localparam logic [3:0] OP_ADD  = 4'd6;
   localparam logic [3:0] OP_SUB  = 4'd7;
   localparam logic [3:0] OP_AND  = 4'd8;
   localparam logic [3:0] OP_OR   = 4'd9;
   localparam logic [3:0] OP_XOR  = 4'd10;

   typedef enum logic {RUN = 1'b0, ERR = 1'b1} state_t;

   state_t                 state_reg, state_next;
   logic [CNT_WIDTH-1:0]   count_reg, count_next;
   logic                   carry_reg, carry_next;
   logic                   done_reg, done_next;
   logic [1:0]             err_reg, err_next;

   logic [DATA_WIDTH-1:0]  mem [DEPTH];
   logic [IDX_WIDTH-1:0]   tos_idx, nos_idx, push_idx;
   logic [DATA_WIDTH-1:0]  t_val, n_val;

   logic                   accept, exec;
   logic                   is_illegal, is_grow, is_under, is_over;
   logic [CNT_WIDTH-1:0]   need;
   logic [DATA_WIDTH:0]    sum, diff;

   logic                   wr_a_en, wr_b_en;
   logic [IDX_WIDTH-1:0]   wr_a_idx, wr_b_idx;
   logic [DATA_WIDTH-1:0]  wr_a_data, wr_b_data;

   // Index arithmetic wraps harmlessly at low counts; the reads below are masked by count.
   assign tos_idx  = IDX_WIDTH'(count_reg - CNT_WIDTH'(1));
   assign nos_idx  = IDX_WIDTH'(count_reg - CNT_WIDTH'(2));
   assign push_idx = IDX_WIDTH'(count_reg);
   assign t_val    = (count_reg != '0) ? mem[tos_idx] : '0;
   assign n_val    = (count_reg >= CNT_WIDTH'(2)) ? mem[nos_idx] : '0;

   assign accept = bus.op_valid && bus.op_ready;
   assign sum    = {1'b0, n_val} + {1'b0, t_val};
   assign diff   = {1'b0, n_val} - {1'b0, t_val};

   always_comb begin
      need    = '0;
      is_grow = 1'b0;
      case (bus.op_code)
         OP_PUSH:          is_grow = 1'b1;
         OP_POP:           need = CNT_WIDTH'(1);
         OP_DUP: begin
            need    = CNT_WIDTH'(1);
            is_grow = 1'b1;
         end
         OP_OVER: begin
            need    = CNT_WIDTH'(2);
            is_grow = 1'b1;
         end
         OP_SWAP, OP_ADD, OP_SUB,
         OP_AND, OP_OR, OP_XOR: need = CNT_WIDTH'(2);
         default:          need = '0;
      endcase
      is_illegal = (bus.op_code > OP_XOR);
      is_under   = (count_reg < need);
      is_over    = is_grow && (count_reg == DEPTH_CNT);
      exec       = accept && !is_illegal && !is_under && !is_over;
   end

   // Datapath: at most two entry writes per op (SWAP needs both ports).
   always_comb begin
      count_next = count_reg;
      carry_next = carry_reg;
      wr_a_en    = 1'b0;
      wr_a_idx   = push_idx;
      wr_a_data  = bus.din;
      wr_b_en    = 1'b0;
      wr_b_idx   = nos_idx;
      wr_b_data  = t_val;
      if (exec) begin
         case (bus.op_code)
            OP_PUSH, OP_DUP, OP_OVER: begin
               wr_a_en    = 1'b1;
               wr_a_idx   = push_idx;
               wr_a_data  = (bus.op_code == OP_PUSH) ? bus.din :
                            (bus.op_code == OP_DUP)  ? t_val : n_val;
               count_next = count_reg + CNT_WIDTH'(1);
            end
            OP_POP: count_next = count_reg - CNT_WIDTH'(1);
            OP_SWAP: begin
               wr_a_en   = 1'b1;
               wr_a_idx  = tos_idx;
               wr_a_data = n_val;
               wr_b_en   = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
               wr_a_en    = 1'b1;
               wr_a_idx   = nos_idx;
               count_next = count_reg - CNT_WIDTH'(1);
               case (bus.op_code)
                  OP_ADD: begin
                     wr_a_data  = sum[DATA_WIDTH-1:0];
                     carry_next = sum[DATA_WIDTH];
                  end
                  OP_SUB: begin
                     wr_a_data  = diff[DATA_WIDTH-1:0];
                     carry_next = diff[DATA_WIDTH];
                  end
                  OP_AND:  wr_a_data = n_val & t_val;
                  OP_OR:   wr_a_data = n_val | t_val;
                  default: wr_a_data = n_val ^ t_val;
               endcase
            end
            default: count_next = count_reg;
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [DATA_WIDTH-1:0] entry_reg;
         always_ff @(posedge clk) begin
            if (wr_a_en && (wr_a_idx == IDX_WIDTH'(gi))) begin
               entry_reg <= wr_a_data;
            end else if (wr_b_en && (wr_b_idx == IDX_WIDTH'(gi))) begin
               entry_reg <= wr_b_data;
            end
         end
         assign mem[gi] = entry_reg;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= RUN;
         count_reg <= '0;
         carry_reg <= 1'b0;
         done_reg  <= 1'b0;
         err_reg   <= 2'b00;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         carry_reg <= carry_next;
         done_reg  <= done_next;
         err_reg   <= err_next;
      end
   end

   // Underflow outranks overflow so OVER on an empty stack reports underflow.
   always_comb begin
      state_next = state_reg;
      err_next   = err_reg;
      done_next  = exec;
      case (state_reg)
         RUN: begin
            if (accept && !exec) begin
               state_next = ERR;
               err_next   = is_illegal ? 2'b11 : (is_under ? 2'b10 : 2'b01);
            end
         end
         default: begin
            if (bus.err_clr) begin
               state_next = RUN;
               err_next   = 2'b00;
            end
         end
      endcase
   end

   always_comb begin
      bus.op_ready = (state_reg == RUN);
      bus.tos      = t_val;
      bus.nos      = n_val;
      bus.count    = count_reg;
      bus.empty    = (count_reg == '0);
      bus.full     = (count_reg == DEPTH_CNT);
      bus.carry    = carry_reg;
      bus.done     = done_reg;
      bus.err_code = err_reg;
   end
endmodule

// File: tb/tb_stack_exec_unit.sv
// Scoreboard bench for stack_exec_unit (DATA_WIDTH=8, DEPTH=4): a queue-based reference
// stack predicts every cycle, plus directed checks of the documented scenarios.
module tb_stack_exec_unit;
   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   typedef struct {
      logic [7:0] tos;
      logic [7:0] nos;
      logic [2:0] count;
      logic       carry;
      logic       done;
      logic       ready;
      logic [1:0] err;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   int   done_seen;

   exp_t       exp_q[$];
   logic [7:0] m_stk[$];
   logic       m_carry;
   logic       m_run;
   logic [1:0] m_err;

   stack_exec_unit_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

   stack_exec_unit #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference model: advances one clock and queues the expected post-edge state.
   task automatic model_cycle(input logic valid, input logic [3:0] code,
                              input logic [7:0] d, input logic clr);
      exp_t       e;
      logic [7:0] t, n;
      logic [8:0] w;
      int         need;
      bit         grow;
      e.done = 1'b0;
      if (m_run && valid) begin
         need = (code <= 1) ? 0 : (code <= 3) ? 1 : 2;
         grow = (code == 1) || (code == 3) || (code == 5);
         if (code > 10) begin
            m_err = 2'b11; m_run = 1'b0;
         end else if (m_stk.size() < need) begin
            m_err = 2'b10; m_run = 1'b0;
         end else if (grow && m_stk.size() == DEPTH) begin
            m_err = 2'b01; m_run = 1'b0;
         end else begin
            e.done = 1'b1;
            case (code)
               1: m_stk.push_back(d);
               2: t = m_stk.pop_back();
               3: m_stk.push_back(m_stk[m_stk.size()-1]);
               4: begin
                  t = m_stk.pop_back(); n = m_stk.pop_back();
                  m_stk.push_back(t); m_stk.push_back(n);
               end
               5: m_stk.push_back(m_stk[m_stk.size()-2]);
               6, 7, 8, 9, 10: begin
                  t = m_stk.pop_back(); n = m_stk.pop_back();
                  case (code)
                     6: begin w = 9'(n) + 9'(t); m_carry = w[8]; m_stk.push_back(w[7:0]); end
                     7: begin m_carry = (t > n); m_stk.push_back(n - t); end
                     8: m_stk.push_back(n & t);
                     9: m_stk.push_back(n | t);
                     default: m_stk.push_back(n ^ t);
                  endcase
               end
               default: ;
            endcase
         end
      end else if (!m_run && clr) begin
         m_run = 1'b1; m_err = 2'b00;
      end
      e.tos   = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 8'h00;
      e.nos   = (m_stk.size() > 1) ? m_stk[m_stk.size()-2] : 8'h00;
      e.count = 3'(m_stk.size());
      e.carry = m_carry;
      e.ready = m_run;
      e.err   = m_err;
      exp_q.push_back(e);
   endtask

   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_checks++; n_fail++;
         $display("FAIL sb_underrun: got empty queue expected an entry");
      end else begin
         e = exp_q.pop_front();
         $display("op=%0d v=%0d clr=%0d -> tos=%02h nos=%02h cnt=%0d c=%0d d=%0d err=%0d",
                  bus.op_code, bus.op_valid, bus.err_clr, bus.tos, bus.nos, bus.count,
                  bus.carry, bus.done, bus.err_code);
         check("tos",   32'(bus.tos),      32'(e.tos));
         check("nos",   32'(bus.nos),      32'(e.nos));
         check("count", 32'(bus.count),    32'(e.count));
         check("empty", 32'(bus.empty),    32'(e.count == 0));
         check("full",  32'(bus.full),     32'(e.count == DEPTH));
         check("carry", 32'(bus.carry),    32'(e.carry));
         check("done",  32'(bus.done),     32'(e.done));
         check("ready", 32'(bus.op_ready), 32'(e.ready));
         check("err",   32'(bus.err_code), 32'(e.err));
      end
      if (bus.done) done_seen++;
   endtask

   task automatic do_op(input logic [3:0] code, input logic [7:0] d);
      bus.op_valid = 1'b1; bus.op_code = code; bus.din = d;
      model_cycle(1'b1, code, d, 1'b0);
      step();
      bus.op_valid = 1'b0; bus.op_code = 4'd0;
   endtask

   task automatic do_clr();
      bus.err_clr = 1'b1;
      model_cycle(1'b0, 4'd0, 8'h00, 1'b1);
      step();
      bus.err_clr = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      #1;
      check("rst_count", 32'(bus.count),    32'd0);
      check("rst_tos",   32'(bus.tos),      32'd0);
      check("rst_ready", 32'(bus.op_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      m_stk.delete(); m_carry = 1'b0; m_run = 1'b1; m_err = 2'b00;
   endtask

   initial begin
      n_checks = 0; n_fail = 0; done_seen = 0;
      rst = 1'b1;
      bus.op_valid = 1'b0; bus.op_code = 4'd0; bus.din = 8'h00; bus.err_clr = 1'b0;
      m_carry = 1'b0; m_run = 1'b1; m_err = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      check("reset_count", 32'(bus.count),    32'd0);
      check("reset_carry", 32'(bus.carry),    32'd0);
      check("reset_done",  32'(bus.done),     32'd0);
      check("reset_err",   32'(bus.err_code), 32'd0);
      check("reset_ready", 32'(bus.op_ready), 32'd1);
      check("reset_empty", 32'(bus.empty),    32'd1);
      @(negedge clk);
      rst = 1'b0;

      // 1: 5 - 3
      do_op(4'd1, 8'h05); do_op(4'd1, 8'h03); do_op(4'd7, 8'h00);
      check("p1_tos", 32'(bus.tos), 32'h02);
      check("p1_count", 32'(bus.count), 32'd1);
      check("p1_carry", 32'(bus.carry), 32'd0);
      check("p1_done_pulses", 32'(done_seen), 32'd3);

      // 2: ADD with carry-out, SUB with borrow
      do_op(4'd1, 8'hF0); do_op(4'd1, 8'h20); do_op(4'd6, 8'h00);
      check("p2_add_tos", 32'(bus.tos), 32'h10);
      check("p2_add_carry", 32'(bus.carry), 32'd1);
      do_op(4'd1, 8'h11); do_op(4'd7, 8'h00);
      check("p2_sub_tos", 32'(bus.tos), 32'hFF);
      check("p2_sub_carry", 32'(bus.carry), 32'd1);

      // 3: fill, overflow, ignored request in ERR, clear
      apply_reset();
      for (int i = 1; i <= 4; i++) do_op(4'd1, 8'(i));
      check("p3_full", 32'(bus.full), 32'd1);
      do_op(4'd1, 8'h05);
      check("p3_err", 32'(bus.err_code), 32'd1);
      check("p3_ready", 32'(bus.op_ready), 32'd0);
      check("p3_tos", 32'(bus.tos), 32'd4);
      do_op(4'd2, 8'h00);
      check("p3_err_hold_count", 32'(bus.count), 32'd4);
      do_clr();
      check("p3_clr_err", 32'(bus.err_code), 32'd0);
      check("p3_clr_tos", 32'(bus.tos), 32'd4);
      do_op(4'd6, 8'h00);
      check("p3_full_binop_clears_full", 32'(bus.full), 32'd0);

      // 4: underflows
      apply_reset();
      do_op(4'd2, 8'h00);
      check("p4_pop_err", 32'(bus.err_code), 32'd2);
      do_clr();
      do_op(4'd1, 8'h07); do_op(4'd4, 8'h00);
      check("p4_swap_err", 32'(bus.err_code), 32'd2);
      check("p4_swap_tos", 32'(bus.tos), 32'd7);
      do_clr();

      // OVER on empty reports underflow
      apply_reset();
      do_op(4'd5, 8'h00);
      check("over_empty_err", 32'(bus.err_code), 32'd2);
      do_clr();

      // 5: SWAP, OVER, illegal opcode
      apply_reset();
      do_op(4'd1, 8'h09); do_op(4'd1, 8'h08); do_op(4'd4, 8'h00); do_op(4'd5, 8'h00);
      check("p5_tos", 32'(bus.tos), 32'd8);
      check("p5_nos", 32'(bus.nos), 32'd9);
      check("p5_count", 32'(bus.count), 32'd3);
      do_op(4'd13, 8'h00);
      check("p5_illegal_err", 32'(bus.err_code), 32'd3);
      check("p5_illegal_count", 32'(bus.count), 32'd3);
      do_clr();

      // Random mix against the reference model
      for (int k = 0; k < 150; k++) begin
         if (!m_run) do_clr();
         else do_op(4'($urandom_range(0, 11)), 8'($urandom_range(0, 255)));
      end
      if (!m_run) do_clr();

      // 6: reset mid-cycle while a request is held
      apply_reset();
      do_op(4'd1, 8'hAA);
      bus.op_valid = 1'b1; bus.op_code = 4'd1; bus.din = 8'hBB;
      #4;
      rst = 1'b1;
      #1;
      check("p6_count", 32'(bus.count), 32'd0);
      check("p6_tos", 32'(bus.tos), 32'd0);
      check("p6_err", 32'(bus.err_code), 32'd0);
      check("p6_ready", 32'(bus.op_ready), 32'd1);
      @(posedge clk);
      #1;
      check("p6_no_accept_in_rst", 32'(bus.count), 32'd0);
      check("p6_no_done_in_rst", 32'(bus.done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      m_stk.delete(); m_carry = 1'b0; m_run = 1'b1; m_err = 2'b00;
      model_cycle(1'b1, 4'd1, 8'hBB, 1'b0);
      step();
      check("p6_first_after_rst", 32'(bus.tos), 32'hBB);
      bus.op_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/stack_exec_unit.md
Name: stack_exec_unit

Overview:
Parametrised operand-stack execution unit for the stack CPU datapath. It holds a LIFO of DATA_WIDTH words and executes one stack or ALU opcode per accepted request, using a valid/ready handshake. It detects overflow, underflow and illegal opcodes, then halts in an error state until it is cleared. The core controller drives it in place of the fixed-width stack.

Parameters:
DATA_WIDTH, 8, word width of stack entries, din and ALU results
DEPTH, 16, maximum number of entries (>=2)
CNT_WIDTH, $clog2(DEPTH+1), width of the occupancy count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
op_valid  input  1  request present
op_ready  output  1  unit can accept a request this cycle
op_code  input  4  operation code, listed under Behaviour
din  input  DATA_WIDTH  operand for PUSH
err_clr  input  1  leave the ERR state
tos  output  DATA_WIDTH  top of stack; 0 when count==0
nos  output  DATA_WIDTH  next on stack; 0 when count<2
count  output  CNT_WIDTH  number of valid entries
empty  output  1  count==0
full  output  1  count==DEPTH
carry  output  1  carry or borrow from the last ADD/SUB
done  output  1  one-cycle pulse, the previous accepted op completed
err_code  output  2  00 none, 01 overflow, 10 underflow, 11 illegal op

Behaviour:
- Reset, asynchronous and effective immediately:
  - state=RUN, count=0, carry=0, done=0, err_code=00.
  - tos=nos=0, op_ready=1.
  - Array contents are don't-care but are never visible.
- Opcodes; "T" is tos and "N" is nos before the op:
  - 0 NOP: no change.
  - 1 PUSH: push din; needs count<DEPTH.
  - 2 POP: drop T; needs count>=1.
  - 3 DUP: push T; needs 1<=count<DEPTH.
  - 4 SWAP: exchange T and N; needs count>=2.
  - 5 OVER: push N; needs 2<=count<DEPTH.
  - 6 ADD, 7 SUB, 8 AND, 9 OR, 10 XOR: pop two, push one (count-1); needs count>=2.
  - SUB computes N-T.
  - 11-15: illegal.
- Arithmetic:
  - Results are modulo 2^DATA_WIDTH.
  - ADD sets carry to the carry-out bit.
  - SUB sets carry=1 when T>N (borrow).
  - All other ops leave carry unchanged.
- Handshake:
  - A request is accepted when op_valid && op_ready at a rising edge.
  - op_ready is a combinational function of state only: 1 in RUN, 0 in ERR.
  - The effect is visible on tos/nos/count/carry the cycle after acceptance; latency is 1.
  - done=1 for exactly that one cycle.
  - Back-to-back requests are accepted every cycle.
- State machine, RUN and ERR:
  - RUN with a legal accepted op: execute and stay in RUN.
  - RUN with an accepted op failing its precondition: no stack, count or carry change, and done stays 0.
    - err_code is set to 01 for overflow (push-type op while full).
    - err_code is set to 10 for underflow.
    - err_code is set to 11 for an illegal opcode.
    - The unit enters ERR.
  - Underflow takes priority over overflow; OVER with count=0 gives 10.
  - ERR: op_ready=0 and requests are ignored; stack contents and outputs are held.
  - err_clr=1 in ERR: next cycle err_code=00, state=RUN, stack contents preserved.
  - err_clr in RUN has no effect.
- Boundaries:
  - PUSH at count==DEPTH-1 reaches full=1, and a further PUSH overflows.
  - A binary op at count==DEPTH is legal and clears full.
- Reset asserted mid-sequence, including in ERR, forces reset values immediately.
  - No request is accepted while rst=1.
  - The first request can be accepted at the first rising edge after deassertion.

Test Plan (DATA_WIDTH=8, DEPTH=4):
1. Reset, then PUSH 0x05, PUSH 0x03, then SUB -> count=1, tos=0x02, carry=0, done pulses 3 times.
2. PUSH 0xF0, PUSH 0x20, then ADD -> tos=0x10, carry=1; then PUSH 0x11 and SUB (0x10-0x11) -> tos=0xFF, carry=1.
3. PUSH 1, 2, 3, 4, giving full=1; then PUSH 5 -> err_code=01, op_ready=0, tos=4, count=4. Then err_clr -> op_ready=1, err_code=00, tos=4.
4. From empty, POP -> err_code=10, count=0. After err_clr, PUSH 7, then SWAP -> err_code=10, tos=7.
5. PUSH 9, PUSH 8, SWAP, then OVER -> tos=8, nos=9, count=3. Then opcode 13 -> err_code=11, state unchanged.
6. PUSH 0xAA, then assert rst mid-cycle while op_valid is held high -> count=0, tos=0, err_code=00, op_ready=1, with no acceptance during rst.
